// File: rtl/riscv_pkg.sv
// Shared hazard-tracking types: scoreboard entry layout, forwarding select codes
// and the writer-match helper used by the hazard unit.
package riscv_pkg;

    localparam int REG_AW_DEF = 5;

    localparam int FWD_RF = 0;
    localparam int FWD_M  = 1;
    localparam int FWD_W  = 2;

    // Unused source fields are stored as x0 so that a match on them is impossible.
    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic                  is_load;
        logic [REG_AW_DEF-1:0] rd;
        logic [REG_AW_DEF-1:0] rs1;
        logic [REG_AW_DEF-1:0] rs2;
    } hazard_entry_t;

    function automatic logic writer_match(input hazard_entry_t e,
                                          input logic [REG_AW_DEF-1:0] rs);
        return e.valid && e.we && (e.rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// DEPTH-entry shift register of in-flight instructions after decode (0=E, 1=M, ...).
// A bubble is inserted at entry 0 when decode is stalled, flushed or empty.
module hazard_scoreboard
    import riscv_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bubble,
    input  hazard_entry_t             din,
    output hazard_entry_t [DEPTH-1:0] ent
);

    hazard_entry_t [DEPTH-1:0] ent_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q <= '0;
        end else begin
            ent_q[0] <= bubble ? hazard_entry_t'('0) : din;
            for (int k = 1; k < DEPTH; k++)
                ent_q[k] <= ent_q[k-1];
        end
    end

    assign ent = ent_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding selects, load-use/interlock stalls, branch
// flushes and saturating event counters. HAZARD_FORWARD_EN enables forwarding.
module hazard_unit
    import riscv_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 32,
    localparam int FWD_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic              dec_rs1_used,
    input  logic              dec_rs2_used,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_we,
    input  logic              dec_is_load,
    input  logic              br_taken_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic [FWD_W-1:0]  fwd_a_e,
    output logic [FWD_W-1:0]  fwd_b_e,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    hazard_entry_t [DEPTH-1:0] ent;
    hazard_entry_t             dec_ent;
    logic [REG_AW_DEF-1:0]     rs1_d, rs2_d;
    logic                      hazard;
    logic [FWD_W-1:0]          fwd_a, fwd_b;
    logic                      unused_ent;

    assign rs1_d = dec_rs1_used ? REG_AW_DEF'(dec_rs1) : '0;
    assign rs2_d = dec_rs2_used ? REG_AW_DEF'(dec_rs2) : '0;

    always_comb begin
        dec_ent         = '0;
        dec_ent.valid   = 1'b1;
        dec_ent.we      = dec_we && (dec_rd != '0);
        dec_ent.is_load = dec_is_load;
        dec_ent.rd      = REG_AW_DEF'(dec_rd);
        dec_ent.rs1     = rs1_d;
        dec_ent.rs2     = rs2_d;
    end

    hazard_scoreboard #(.DEPTH(DEPTH)) u_sb (
        .clk    (clk),
        .rst    (rst),
        .bubble (flush_e || !dec_valid),
        .din    (dec_ent),
        .ent    (ent)
    );

`ifdef HAZARD_FORWARD_EN
    // Only a load sitting in E can't be forwarded in time; every other producer bypasses.
    always_comb begin
        hazard = dec_valid && ent[0].is_load &&
                 (writer_match(ent[0], rs1_d) || writer_match(ent[0], rs2_d));
        fwd_a  = FWD_W'(FWD_RF);
        fwd_b  = FWD_W'(FWD_RF);
        if (ent[0].valid) begin
            // Scan oldest to youngest so the youngest matching producer wins.
            for (int k = DEPTH - 1; k >= 1; k--) begin
                if (!(k == FWD_M && ent[k].is_load)) begin
                    if (writer_match(ent[k], ent[0].rs1)) fwd_a = FWD_W'(k);
                    if (writer_match(ent[k], ent[0].rs2)) fwd_b = FWD_W'(k);
                end
            end
        end
    end
`else
    // Without bypass, wait until the producer reaches W (register file write-through).
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++)
            if (writer_match(ent[k], rs1_d) || writer_match(ent[k], rs2_d))
                hazard = 1'b1;
        hazard = hazard && dec_valid;
        fwd_a  = FWD_W'(FWD_RF);
        fwd_b  = FWD_W'(FWD_RF);
    end
`endif

    assign unused_ent = ^ent;

    assign stall_d = hazard && !br_taken_e && !rst;
    assign stall_f = stall_d;
    assign flush_d = br_taken_e && !rst;
    assign flush_e = stall_d || flush_d;
    assign fwd_a_e = rst ? '0 : fwd_a;
    assign fwd_b_e = rst ? '0 : fwd_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_d && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (br_taken_e && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed per-cycle vectors push hand-computed
// expectations; a negedge monitor pops and compares. Follows HAZARD_FORWARD_EN.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dec_valid = 1'b0;
    logic [4:0]  dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
    logic        dec_rs1_used = 1'b0, dec_rs2_used = 1'b0;
    logic        dec_we = 1'b0, dec_is_load = 1'b0, br_taken_e = 1'b0;
    logic        stall_f, stall_d, flush_d, flush_e;
    logic [1:0]  fwd_a_e, fwd_b_e;
    logic [31:0] stall_cnt, flush_cnt;

    typedef struct {
        string       name;
        logic        sf, sd, fd, fe;
        logic [1:0]  fa, fb;
        logic [31:0] sc, fc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_sc = '0;
    logic [31:0] exp_fc = '0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk          (clk),
        .rst          (rst),
        .dec_valid    (dec_valid),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_rs1_used (dec_rs1_used),
        .dec_rs2_used (dec_rs2_used),
        .dec_rd       (dec_rd),
        .dec_we       (dec_we),
        .dec_is_load  (dec_is_load),
        .br_taken_e   (br_taken_e),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .fwd_a_e      (fwd_a_e),
        .fwd_b_e      (fwd_b_e),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    // One decode cycle: drive inputs after the edge and queue what the outputs must be.
    task automatic step(input string name, input logic r, input logic dv,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic we, input logic ld,
                        input logic br, input logic st, input int fa, input int fb);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; dec_valid = dv; dec_rs1 = rs1; dec_rs1_used = u1;
        dec_rs2 = rs2; dec_rs2_used = u2; dec_rd = rd; dec_we = we;
        dec_is_load = ld; br_taken_e = br;
        e.name = name;
        if (r) begin
            exp_sc = '0; exp_fc = '0;
            e.sf = 0; e.sd = 0; e.fd = 0; e.fe = 0; e.fa = 0; e.fb = 0;
        end else begin
            e.sf = st; e.sd = st; e.fd = br; e.fe = st | br;
            e.fa = 2'(fa); e.fb = 2'(fb);
        end
        e.sc = exp_sc;
        e.fc = exp_fc;
        q.push_back(e);
        if (!r) begin
            exp_sc = exp_sc + {31'b0, st};
            exp_fc = exp_fc + {31'b0, br};
        end
    endtask

    task automatic op(input string name, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic ld, input logic br, input logic st,
                      input int fa, input int fb);
        step(name, 1'b0, 1'b1, rs1, u1, rs2, u2, rd, 1'b1, ld, br, st, fa, fb);
    endtask

    task automatic nop(input string name, input int fa, input int fb);
        step(name, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, fa, fb);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e, stall_cnt, flush_cnt} !==
                {e.sf, e.sd, e.fd, e.fe, e.fa, e.fb, e.sc, e.fc}) begin
                errors++;
                $display("FAIL %s: got sf=%b sd=%b fd=%b fe=%b fa=%0d fb=%0d sc=%0d fc=%0d, want sf=%b sd=%b fd=%b fe=%b fa=%0d fb=%0d sc=%0d fc=%0d",
                         e.name, stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e,
                         stall_cnt, flush_cnt, e.sf, e.sd, e.fd, e.fe, e.fa, e.fb, e.sc, e.fc);
            end
        end
    end

    initial begin
        // Reset held with a hazard-looking decode and a taken branch: all outputs stay 0.
        step("reset_a", 1, 1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 1, 0, 0, 0);
        step("reset_b", 1, 1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 1, 0, 0, 0);
`ifdef HAZARD_FORWARD_EN
        op ("add_x1",          5'd1,  5'd3, 1, 5'd4, 1, 0, 0, 0, 0, 0);
        op ("add_x2_dep",      5'd2,  5'd1, 1, 5'd3, 1, 0, 0, 0, 0, 0);
        nop("fwd_from_m",      riscv_pkg::FWD_M, 0);
        op ("lw_x5",           5'd5,  5'd6, 1, 5'd0, 0, 1, 0, 0, 0, 0);
        op ("ld_use_stall",    5'd6,  5'd5, 1, 5'd5, 1, 0, 0, 1, 0, 0);
        op ("ld_use_release",  5'd6,  5'd5, 1, 5'd5, 1, 0, 0, 0, 0, 0);
        nop("fwd_from_w",      riscv_pkg::FWD_W, riscv_pkg::FWD_W);
        op ("lw_x7",           5'd7,  5'd1, 1, 5'd0, 0, 1, 0, 0, 0, 0);
        op ("br_over_ld_use",  5'd8,  5'd7, 1, 5'd0, 1, 0, 1, 0, 0, 0);
        nop("post_flush",      0, 0);
        op ("addi_x0",         5'd0,  5'd0, 1, 5'd0, 0, 0, 0, 0, 0, 0);
        op ("lw_x0",           5'd0,  5'd0, 1, 5'd0, 0, 1, 0, 0, 0, 0);
        op ("read_x0",         5'd9,  5'd0, 1, 5'd0, 1, 0, 0, 0, 0, 0);
        nop("x0_no_fwd",       0, 0);
        op ("add_x1_a",        5'd1,  5'd3, 1, 5'd4, 1, 0, 0, 0, 0, 0);
        op ("add_x1_b",        5'd1,  5'd3, 1, 5'd4, 1, 0, 0, 0, 0, 0);
        op ("read_x1_twice",   5'd10, 5'd1, 1, 5'd1, 1, 0, 0, 0, 0, 0);
        nop("youngest_wins",   riscv_pkg::FWD_M, riscv_pkg::FWD_M);
        op ("lw_x11",          5'd11, 5'd6, 1, 5'd0, 0, 1, 0, 0, 0, 0);
        op ("ld_use_pre_rst",  5'd12, 5'd11, 1, 5'd0, 0, 0, 0, 1, 0, 0);
`else
        op ("add_x1",          5'd1,  5'd3, 1, 5'd4, 1, 0, 0, 0, 0, 0);
        op ("add_x2_dep",      5'd2,  5'd1, 1, 5'd3, 1, 0, 0, 1, 0, 0);
        op ("add_x2_hold",     5'd2,  5'd1, 1, 5'd3, 1, 0, 0, 1, 0, 0);
        op ("add_x2_go",       5'd2,  5'd1, 1, 5'd3, 1, 0, 0, 0, 0, 0);
        op ("lw_x5",           5'd5,  5'd6, 1, 5'd0, 0, 1, 0, 0, 0, 0);
        op ("ld_dep_stall_e",  5'd6,  5'd5, 1, 5'd5, 1, 0, 0, 1, 0, 0);
        op ("ld_dep_stall_m",  5'd6,  5'd5, 1, 5'd5, 1, 0, 0, 1, 0, 0);
        op ("ld_dep_go",       5'd6,  5'd5, 1, 5'd5, 1, 0, 0, 0, 0, 0);
        nop("nop_a",           0, 0);
        op ("lw_x7",           5'd7,  5'd1, 1, 5'd0, 0, 1, 0, 0, 0, 0);
        op ("br_over_hazard",  5'd8,  5'd7, 1, 5'd0, 1, 0, 1, 0, 0, 0);
        nop("post_flush",      0, 0);
        op ("addi_x0",         5'd0,  5'd0, 1, 5'd0, 0, 0, 0, 0, 0, 0);
        op ("lw_x0",           5'd0,  5'd0, 1, 5'd0, 0, 1, 0, 0, 0, 0);
        op ("read_x0",         5'd9,  5'd0, 1, 5'd0, 1, 0, 0, 0, 0, 0);
        nop("x0_no_fwd",       0, 0);
        op ("add_x1_c",        5'd1,  5'd3, 1, 5'd4, 1, 0, 0, 0, 0, 0);
        nop("gap",             0, 0);
        op ("rs2_dep_in_m",    5'd3,  5'd4, 1, 5'd1, 1, 0, 0, 1, 0, 0);
        op ("rs2_dep_go",      5'd3,  5'd4, 1, 5'd1, 1, 0, 0, 0, 0, 0);
        op ("lw_x11",          5'd11, 5'd6, 1, 5'd0, 0, 1, 0, 0, 0, 0);
        op ("ld_dep_pre_rst",  5'd12, 5'd11, 1, 5'd0, 0, 0, 0, 1, 0, 0);
`endif
        step("rst_mid_stall", 1, 1, 5'd11, 1, 5'd0, 0, 5'd12, 1, 0, 0, 0, 0, 0);
        op ("after_rst",       5'd12, 5'd11, 1, 5'd0, 0, 0, 0, 0, 0, 0);
        nop("no_stale_fwd",    0, 0);
        op ("lw_x13",          5'd13, 5'd3, 1, 5'd0, 0, 1, 0, 0, 0, 0);
        op ("unused_rs2",      5'd14, 5'd0, 0, 5'd13, 0, 0, 0, 0, 0, 0);
        op ("br_plain",        5'd15, 5'd3, 1, 5'd0, 0, 0, 1, 0, 0, 0);
        nop("end_a",           0, 0);
        nop("end_b",           0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
